// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between the player (port 0)
// and the host game-state sender (port 1), with done/timeout handling and an inter-byte gap.
module tx_arbiter #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       ack0,
    output logic       ack1,
    output logic [1:0] grant,
    output logic       err_timeout,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    GAP_LOAD = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } state_t;

    state_t        state;
    logic          rr_ptr;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    gap_cnt;
    logic          win;

    // Winner index: a lone request wins outright, a tie goes to rr_ptr.
    always_comb begin
        win = (req0 && req1) ? rr_ptr : req1;
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            grant       <= 2'b00;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
            rr_ptr      <= 1'b0;
            tmo_cnt     <= '0;
            gap_cnt     <= 8'd0;
        end else begin
            tx_start    <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (!tx_busy && (req0 || req1)) begin
                        grant    <= win ? 2'b10 : 2'b01;
                        tx_data  <= win ? data1 : data0;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        ack0    <= grant[0];
                        ack1    <= grant[1];
                        grant   <= 2'b00;
                        rr_ptr  <= ~grant[1];
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abandon the byte; moving rr_ptr keeps the other port from starving.
                        err_timeout <= 1'b1;
                        grant       <= 2'b00;
                        rr_ptr      <= ~grant[1];
                        gap_cnt     <= GAP_LOAD;
                        state       <= GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
